captura_datos_param: RTL and testbench

CAPTURA_DATOS_PARAM -- requirements
Module: captura_datos_param

---
 rtl/captura_datos_param.sv | 165 ++++++++++++++++
 tb/tb_captura_datos_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/captura_datos_param.sv
// ============================================================================
//  Module   : captura_datos_param
//  Purpose  : Captures RGB565 camera bytes and writes packed pixels to a DP-RAM.
//             Optional 2:1 decimation when CAPTURA_DECIM_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module captura_datos_param #(
    parameter int H_PIX  = 160,
    parameter int V_LIN  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              PCLK,
    input  logic              RSTN,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        D,
    input  logic [1:0]        MODE,
    output logic [15:0]       DP_RAM_data_in,
    output logic [ADDR_W-1:0] DP_RAM_addr_in,
    output logic              DP_RAM_regW,
    output logic              FRAME_DONE,
    output logic              LINE_ERR
);

    localparam int c_col_w  = $clog2(H_PIX + 2);
    localparam int c_line_w = $clog2(V_LIN + 1);
    localparam logic [c_col_w-1:0]  c_hpix    = c_col_w'(H_PIX);
    localparam logic [c_col_w-1:0]  c_col_max = c_col_w'(H_PIX + 1);
    localparam logic [c_line_w-1:0] c_vlin    = c_line_w'(V_LIN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_phase;
    logic                r_href_q;
    logic [7:0]          r_hi;
    logic [c_col_w-1:0]  r_col;
    logic [c_line_w-1:0] r_line;
    logic [ADDR_W-1:0]   r_row_base;
    logic [1:0]          r_mode;
    logic [15:0]         r_data;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic                r_frame_done;
    logic                r_err;

    logic                w_active, w_start, w_line_ok, w_col_ok;
    logic                w_keep, w_row_adv;
    logic [ADDR_W-1:0]   w_col_addr, c_row_step;
    logic [15:0]         w_pix, w_packed;

    always_ff @(posedge PCLK or negedge RSTN) begin
        if (!RSTN) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (VSYNC)  w_state_nxt = SYNC;
            SYNC:    if (!VSYNC) w_state_nxt = CAPTURE;
            CAPTURE: if (VSYNC)  w_state_nxt = SYNC;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_active  = (r_state == CAPTURE) && !VSYNC;
    assign w_start   = (r_state == SYNC) && !VSYNC;
    assign w_line_ok = (r_line < c_vlin);
    assign w_col_ok  = (r_col < c_hpix);
    assign w_pix     = {r_hi, D};

`ifdef CAPTURA_DECIM_EN
    // Even columns of even lines only; the row base advances every second line.
    assign w_keep     = !r_col[0] && !r_line[0];
    assign w_row_adv  = r_line[0];
    assign w_col_addr = ADDR_W'(r_col >> 1);
    assign c_row_step = ADDR_W'(H_PIX / 2);
`else
    assign w_keep     = 1'b1;
    assign w_row_adv  = 1'b1;
    assign w_col_addr = ADDR_W'(r_col);
    assign c_row_step = ADDR_W'(H_PIX);
`endif

    always_comb begin
        w_packed = w_pix;
        case (r_mode)
            2'b00:   w_packed = {8'h00, w_pix[15:13], w_pix[10:8], w_pix[4:3]};
            2'b01:   w_packed = {4'h0, w_pix[15:12], w_pix[10:7], w_pix[4:1]};
            default: w_packed = w_pix;
        endcase
    end

    always_ff @(posedge PCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_phase      <= 1'b0;
            r_href_q     <= 1'b0;
            r_hi         <= 8'h00;
            r_col        <= '0;
            r_line       <= '0;
            r_row_base   <= '0;
            r_mode       <= 2'b10;
            r_data       <= 16'h0000;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_frame_done <= (r_state == CAPTURE) && VSYNC;
            r_href_q     <= w_active && HREF;
            if (w_start) begin
                r_phase    <= 1'b0;
                r_col      <= '0;
                r_line     <= '0;
                r_row_base <= '0;
                r_err      <= 1'b0;
                r_mode     <= MODE;
            end else if (w_active && HREF) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_hi <= D;
                end else begin
                    // Lines beyond the frame are silently ignored.
                    if (w_line_ok) begin
                        if (!w_col_ok) begin
                            r_err <= 1'b1;
                        end else if (w_keep) begin
                            r_we   <= 1'b1;
                            r_data <= w_packed;
                            r_addr <= r_row_base + w_col_addr;
                        end
                    end
                    if (r_col != c_col_max) r_col <= r_col + c_col_w'(1);
                end
            end else begin
                r_phase <= 1'b0;
                if (w_active && r_href_q) begin
                    r_col <= '0;
                    if (w_line_ok) begin
                        if (r_col != c_hpix) r_err <= 1'b1;
                        r_line <= r_line + c_line_w'(1);
                        if (w_row_adv) r_row_base <= r_row_base + c_row_step;
                    end
                end
            end
        end
    end

    assign DP_RAM_data_in = r_data;
    assign DP_RAM_addr_in = r_addr;
    assign DP_RAM_regW    = r_we;
    assign FRAME_DONE     = r_frame_done;
    assign LINE_ERR       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_captura_datos_param.sv
// ============================================================================
//  Module   : tb_captura_datos_param
//  Purpose  : Directed scoreboard bench for captura_datos_param (H_PIX=4, V_LIN=2).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_captura_datos_param;

    localparam int H_PIX  = 4;
    localparam int V_LIN  = 2;
    localparam int ADDR_W = 4;

    logic              pclk = 1'b0;
    logic              rstn;
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic [1:0]        mode;
    logic [15:0]       dp_data;
    logic [ADDR_W-1:0] dp_addr;
    logic              dp_we;
    logic              frame_done;
    logic              line_err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb[$];
    logic [31:0] r_exp;

    captura_datos_param #(.H_PIX(H_PIX), .V_LIN(V_LIN), .ADDR_W(ADDR_W)) dut (
        .PCLK           (pclk),
        .RSTN           (rstn),
        .VSYNC          (vsync),
        .HREF           (href),
        .D              (d),
        .MODE           (mode),
        .DP_RAM_data_in (dp_data),
        .DP_RAM_addr_in (dp_addr),
        .DP_RAM_regW    (dp_we),
        .FRAME_DONE     (frame_done),
        .LINE_ERR       (line_err)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(posedge pclk) begin
        #1;
        if (dp_we === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_write: observed write addr %0h data %0h expected no write", dp_addr, dp_data);
            end
            if (sb.size() != 0) begin
                r_exp = sb.pop_front();
                chk("wr_addr", 32'(dp_addr), {16'h0000, r_exp[31:16]});
                chk("wr_data", 32'(dp_data), {16'h0000, r_exp[15:0]});
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #3;
    endtask

    task automatic push(input int addr, input logic [15:0] data);
        sb.push_back({16'(addr), data});
    endtask

    task automatic pixel(input logic [7:0] hi, input logic [7:0] lo);
        href = 1'b1; d = hi; tick();
        d = lo; tick();
    endtask

    task automatic line_end();
        href = 1'b0; d = 8'h00; tick(); tick();
    endtask

    task automatic frame_start(input logic [1:0] m);
        href = 1'b0; mode = m; vsync = 1'b1; tick(); tick();
        vsync = 1'b0; tick();
    endtask

    task automatic frame_end();
        href = 1'b0; vsync = 1'b1; tick();
        chk("frame_done_pulse", 32'(frame_done), 32'd1);
        tick();
        chk("frame_done_single", 32'(frame_done), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; vsync = 1'b0; href = 1'b0; d = 8'h00; mode = 2'b10;
        tick(); tick();
        chk("rst_data", 32'(dp_data), 32'd0);
        chk("rst_addr", 32'(dp_addr), 32'd0);
        chk("rst_we", 32'(dp_we), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_line_err", 32'(line_err), 32'd0);
        rstn = 1'b1; tick();

`ifdef CAPTURA_DECIM_EN
        frame_start(2'b10);
        push(0, 16'hA000);
        push(1, 16'hA202);
        for (int ln = 0; ln < 2; ln++) begin
            for (int p = 0; p < 4; p++) pixel(8'hA0 + 8'(ln * 16 + p), 8'(ln * 16 + p));
            line_end();
        end
        chk("decim_line_err", 32'(line_err), 32'd0);
        frame_end();
`else
        // Full frame, RGB565 passthrough, plus an out-of-frame third line.
        frame_start(2'b10);
        for (int ln = 0; ln < 2; ln++) begin
            for (int p = 0; p < 4; p++) begin
                push(ln * 4 + p, 16'hF800);
                pixel(8'hF8, 8'h00);
            end
            line_end();
        end
        for (int p = 0; p < 5; p++) pixel(8'h12, 8'h34);
        line_end();
        chk("full_line_err", 32'(line_err), 32'd0);
        frame_end();

        // RGB332, with a mid-frame MODE change that must not take effect.
        frame_start(2'b00);
        push(0, 16'h001C);
        pixel(8'h07, 8'hE0);
        mode = 2'b01;
        push(1, 16'h001C);
        pixel(8'h07, 8'hE0);
        push(2, 16'h0003);
        pixel(8'h00, 8'h1F);
        line_end();
        frame_end();

        // RGB444 and reserved mode (behaves as RGB565).
        frame_start(2'b01);
        chk("err_cleared_frame", 32'(line_err), 32'd0);
        push(0, 16'h00F0);
        pixel(8'h07, 8'hE0);
        push(1, 16'h0F00);
        pixel(8'hF8, 8'h00);
        line_end();
        frame_end();
        frame_start(2'b11);
        push(0, 16'h07E0);
        pixel(8'h07, 8'hE0);
        line_end();
        frame_end();

        // Long line then short line; LINE_ERR sticky until next frame.
        frame_start(2'b10);
        for (int p = 0; p < 5; p++) begin
            if (p < 4) push(p, {8'hA0 + 8'(p), 8'(p)});
            pixel(8'hA0 + 8'(p), 8'(p));
            if (p == 3) chk("err_before_overflow", 32'(line_err), 32'd0);
        end
        chk("err_on_overflow", 32'(line_err), 32'd1);
        line_end();
        for (int p = 0; p < 3; p++) begin
            push(4 + p, {8'hB0 + 8'(p), 8'h10 + 8'(p)});
            pixel(8'hB0 + 8'(p), 8'h10 + 8'(p));
        end
        line_end();
        chk("err_sticky", 32'(line_err), 32'd1);
        frame_end();
        chk("err_sticky_after_frame", 32'(line_err), 32'd1);
        for (int p = 0; p < 2; p++) pixel(8'hCC, 8'hDD);
        href = 1'b0; tick();
        vsync = 1'b0; tick();
        chk("err_cleared_start", 32'(line_err), 32'd0);

        // Asynchronous reset mid-line 0, then HREF without a new VSYNC.
        push(0, 16'hF800);
        pixel(8'hF8, 8'h00);
        href = 1'b1; d = 8'h55;
        rstn = 1'b0; #1;
        chk("async_rst_we", 32'(dp_we), 32'd0);
        chk("async_rst_addr", 32'(dp_addr), 32'd0);
        chk("async_rst_data", 32'(dp_data), 32'd0);
        tick();
        rstn = 1'b1;
        for (int p = 0; p < 4; p++) pixel(8'h77, 8'h88);
        line_end();
        chk("no_capture_after_rst_err", 32'(line_err), 32'd0);
        vsync = 1'b1; tick();
        chk("no_frame_done_from_idle", 32'(frame_done), 32'd0);
        tick();
        vsync = 1'b0; tick();
        push(0, 16'h1234);
        pixel(8'h12, 8'h34);
        line_end();
        frame_end();
`endif

        tick(); tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
